// File: rtl/hilo_muldiv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hilo_muldiv_pkg : op encodings, operand-select codes and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package hilo_muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [2:0] SEL_PB   = 3'b000;
    localparam logic [2:0] SEL_HI   = 3'b001;
    localparam logic [2:0] SEL_LO   = 3'b010;
    localparam logic [2:0] SEL_PC   = 3'b011;
    localparam logic [2:0] SEL_SEXT = 3'b100;
    localparam logic [2:0] SEL_ZEXT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_muldiv_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_step : one shift-add (multiply) or restore-subtract (divide) iteration
// Rev 1.0
// ----------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign w_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);

    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    assign w_shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    assign w_ge      = (w_shifted >= {1'b0, opnd_i});
    assign w_diff    = w_shifted[WIDTH-1:0] - opnd_i;

    always_comb begin
        acc_o = {w_sum, acc_i[WIDTH-1:1]};
        if (is_div) begin
            acc_o = {(w_ge ? w_diff : w_shifted[WIDTH-1:0]), acc_i[WIDTH-2:0], w_ge};
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hilo_muldiv_ctrl : iterative MULT/DIV sequencer owning HI/LO, MT/MF service
// Rev 1.0
// ----------------------------------------------------------------------------
module hilo_muldiv_ctrl
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mt_we,
    input  logic             mt_sel,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             mf_req,
    input  logic             mf_sel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [2:0]       si_sel,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             op_q, op_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;

    logic                   w_is_div;
    logic                   w_a_neg, w_b_neg;
    logic [WIDTH-1:0]       w_abs_a, w_abs_b;
    logic [2*WIDTH-1:0]     w_step_acc;
    logic [2*WIDTH-1:0]     w_prod_fix;
    logic [WIDTH-1:0]       w_quo_fix, w_rem_fix;
    logic                   w_div0;

    assign w_is_div = op_q[1];
    assign w_a_neg  = op_q[0] & a_q[WIDTH-1];
    assign w_b_neg  = op_q[0] & b_q[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -a_q : a_q;
    assign w_abs_b  = w_b_neg ? -b_q : b_q;
    assign w_div0   = (b_q == '0);

    assign w_prod_fix = neg_quo_q ? -acc_q : acc_q;
    assign w_quo_fix  = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign w_rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (w_is_div),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (w_step_acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = rs_val;
                    b_d     = rt_val;
                    state_d = ST_PREP;
                end else if (mt_we) begin
                    if (mt_sel) lo_d = mt_data;
                    else        hi_d = mt_data;
                end
            end
            ST_PREP: begin
                neg_quo_d = w_a_neg ^ w_b_neg;
                neg_rem_d = w_a_neg;
                // Divide walks the dividend MSB first; multiply walks the multiplier LSB first.
                acc_d     = {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                opnd_d    = w_is_div ? w_abs_b : w_abs_a;
                cnt_d     = CNT_W'(WIDTH - 1);
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                acc_d = w_step_acc;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (!w_is_div) begin
                    hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = w_prod_fix[WIDTH-1:0];
                end else if (w_div0) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = w_rem_fix;
                    lo_d = w_quo_fix;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign hi     = hi_q;
    assign lo     = lo_q;
    assign done   = done_q;
    assign busy   = (state_q != ST_IDLE);
    assign stall  = busy & (mf_req | mt_we | start);
    assign si_sel = (mf_req & ~stall) ? (mf_sel ? SEL_LO : SEL_HI) : SEL_PB;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hilo_muldiv_ctrl : directed vector table plus multi-cycle corner sequences
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mt_we = 1'b0;
    logic        mt_sel = 1'b0;
    logic [31:0] mt_data = '0;
    logic        mf_req = 1'b0;
    logic        mf_sel = 1'b0;
    logic [31:0] hi, lo;
    logic [2:0]  si_sel;
    logic        busy, done, stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    hilo_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .mt_we   (mt_we),
        .mt_sel  (mt_sel),
        .mt_data (mt_data),
        .mf_req  (mf_req),
        .mf_sel  (mf_sel),
        .hi      (hi),
        .lo      (lo),
        .si_sel  (si_sel),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op at a negedge and wait (bounded) for done; returns edges after the start edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{2'b00, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A};
        vecs[6]  = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{2'b11, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[10] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[11] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

        // Reset state
        #12;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check($sformatf("vec%0d latency", i), n, 34);
            check($sformatf("vec%0d hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d lo", i), lo, vecs[i].lo);
            check($sformatf("vec%0d busy_in_done", i), {31'b0, busy}, 32'h0);
        end

        // MF read colliding with an in-flight multiply
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_val = 32'd7; rt_val = 32'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        mf_req = 1'b1; mf_sel = 1'b1;
        #1;
        n = 0;
        while (!done && n < 60) begin
            check("mf stall while busy", {31'b0, stall}, 32'h1);
            check("mf si_sel while busy", {29'b0, si_sel}, 32'h0);
            @(negedge clk);
            n++;
        end
        check("mf done seen", {31'b0, done}, 32'h1);
        check("mf stall in done", {31'b0, stall}, 32'h0);
        check("mf si_sel in done", {29'b0, si_sel}, 32'h2);
        check("mf lo in done", lo, 32'd42);
        mf_sel = 1'b0;
        #1;
        check("mf si_sel HI", {29'b0, si_sel}, 32'h1);
        @(negedge clk);
        mf_req = 1'b0;
        #1;
        check("si_sel idle no req", {29'b0, si_sel}, 32'h0);

        // MT writes in IDLE, then start colliding with mt_we
        @(negedge clk);
        mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'hDEADBEEF;
        @(negedge clk);
        check("mthi hi", hi, 32'hDEADBEEF);
        mt_sel = 1'b1; mt_data = 32'h01234567;
        @(negedge clk);
        check("mtlo lo", lo, 32'h01234567);
        check("mtlo hi kept", hi, 32'hDEADBEEF);
        mt_sel = 1'b0; mt_data = 32'h12345678;
        start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd4;
        @(negedge clk);
        start = 1'b0;
        check("start wins hi", hi, 32'hDEADBEEF);
        check("start wins busy", {31'b0, busy}, 32'h1);
        check("mt stall while busy", {31'b0, stall}, 32'h1);
        @(negedge clk);
        mt_we = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("start wins result hi", hi, 32'h0);
        check("start wins result lo", lo, 32'd12);

        // Async reset in the middle of a divide
        @(negedge clk);
        mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'hAAAA5555;
        @(negedge clk);
        mt_we = 1'b0;
        start = 1'b1; op = 2'b10; rs_val = 32'd1000; rt_val = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("pre-reset busy", {31'b0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst hi", hi, 32'h0);
        check("async rst lo", lo, 32'h0);
        check("async rst busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst busy", {31'b0, busy}, 32'h0);
        check("post-rst done", {31'b0, done}, 32'h0);
        run_op(2'b10, 32'd1000, 32'd3, n);
        check("post-rst latency", n, 34);
        check("post-rst hi", hi, 32'd1);
        check("post-rst lo", lo, 32'd333);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the HI and LO registers feeding the operand selector of the MIPS datapath.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles, and services MTHI/MTLO writes.
- Drives the 3-bit operand-select code for MFHI/MFLO reads (001 = HI, 010 = LO).
- Raises a pipeline stall while a read, write or new start collides with an in-flight operation.

Parameters:
- WIDTH, 32, operand/HI/LO width. Iteration count equals WIDTH.
- CNT_W, 6, width of the iteration counter. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  issue a mul/div op, sampled in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rs_val  in  WIDTH  multiplicand / dividend.
- rt_val  in  WIDTH  multiplier / divisor.
- mt_we  in  1  MTHI/MTLO write strobe.
- mt_sel  in  1  0 selects HI, 1 selects LO.
- mt_data  in  WIDTH  write data.
- mf_req  in  1  MFHI/MFLO in decode.
- mf_sel  in  1  0 selects HI, 1 selects LO.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- si_sel  out  3  operand-select code.
- busy  out  1  op in flight.
- done  out  1  one-cycle completion pulse.
- stall  out  1  hold the pipeline.

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, all internal accumulators cleared. Reset mid-operation aborts the op; HI/LO read 0 afterwards.
- States: IDLE -> PREP -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 latches op, rs_val, rt_val and moves to PREP.
  - mt_we=1 (with start=0) writes mt_data to HI or LO at the edge.
  - start and mt_we in the same IDLE cycle: start wins, the write is dropped.
- PREP (1 cycle):
  - Signed ops take absolute values and record the result signs.
  - neg_q = sign(rs) XOR sign(rt); neg_r = sign(rs).
  - Unsigned ops pass operands through unchanged.
  - Sets counter=WIDTH-1.
- RUN (WIDTH cycles, counter counts down to 0):
  - Multiply: shift-add, 2*WIDTH-bit product accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first. Partial remainder is WIDTH+1 bits.
- FIX (1 cycle):
  - Signed multiply with neg_q: product is negated (two's complement, 2*WIDTH bits).
  - Signed divide: quotient negated if neg_q; remainder negated if neg_r.
  - At the exit edge: HI <= product[2W-1:W] or remainder; LO <= product[W-1:0] or quotient. The same edge asserts done=1 for exactly one cycle.
- Latency: start sampled at edge 0; hi/lo updated and done=1 after edge WIDTH+2, i.e. 34 cycles for WIDTH=32. Next start is accepted in the done cycle.
- busy=1 in PREP, RUN and FIX.
- Divide by zero (rt=0, DIV or DIVU): HI=rs_val (original, unsigned view), LO=all ones. Same latency; no exception.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, the natural result of the wrap-around.
- stall = busy & (mf_req | mt_we | start). Stalled requests are ignored and must be re-presented; the pipeline holds them.
- si_sel:
  - mf_req=1 and stall=0: 3'b001 if mf_sel=0, 3'b010 if mf_sel=1.
  - Otherwise 3'b000 (PB).
  - Combinational.
- hi/lo reflect registers directly; there is no bypass of mt_data into the same-cycle read.

Decomposition:
- Shared package holds:
  - Op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV.
  - Operand-select constants SEL_PB=000, SEL_HI=001, SEL_LO=010, SEL_PC=011, SEL_SEXT=100, SEL_ZEXT=101, reused by the operand selector and decode.
  - State enum.
- One natural sub-module: muldiv_step.
  - Combinational; performs one shift-add or restore-subtract iteration given the accumulator and the op type.
  - The controller owns the FSM, counter, sign fixup and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF * 0x00000002 -> done 34 cycles after start; HI=0x00000001, LO=0xFFFFFFFE.
- MULT -3 (0xFFFFFFFD) * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Separately, DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> HI=0x00000064, LO=0xFFFFFFFF. Separately, DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULTU 7*6, then assert mf_req (mf_sel=1) in cycle 5 -> stall=1 and si_sel=000 until done. In the done cycle stall=0, si_sel=010, lo=42.
- IDLE: mt_we HI=0xDEADBEEF -> next cycle hi=0xDEADBEEF. Then start and mt_we together -> op runs and the write is dropped.
- Start DIVU, pull rst_n low at RUN cycle 10 -> outputs clear immediately (async). After release: state IDLE, busy=0, a new op completes correctly.
